// File: rtl/fakeram130_ctrl_pkg.sv
// Shared constants, state type and request layout for the fakeram130_256x95 controller.
package fakeram130_ctrl_pkg;

  localparam int unsigned DefBits      = 95;
  localparam int unsigned DefWordDepth = 256;
  localparam int unsigned DefAddrWidth = 8;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } fakeram_ctrl_state_e;

  typedef struct packed {
    logic                    we;
    logic [DefAddrWidth-1:0] addr;
    logic [DefBits-1:0]      data;
    logic [DefBits-1:0]      mask;
  } fakeram_req_t;

endpackage

// File: rtl/fakeram_ctrl_rsp_fifo.sv
// Shift-register response FIFO: entry 0 is the registered head, push and pop may coincide.
module fakeram_ctrl_rsp_fifo #(
  parameter  int unsigned Width = 95,
  parameter  int unsigned Depth = 3,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_in,
  input  logic [Width-1:0] push_data_in,
  input  logic             pop_in,
  output logic             valid_out,
  output logic [Width-1:0] data_out,
  output logic [CntW-1:0]  count_out
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [CntW-1:0]  count_q, count_d;
  logic             pop;

  assign pop = pop_in & (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[Depth-1] = '0;
      count_d        = count_q - CntW'(1);
    end
    // Credits upstream guarantee a free slot, so a push is never dropped.
    if (push_in) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (CntW'(i) == count_d) mem_d[i] = push_data_in;
      end
      count_d = count_d + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign valid_out = (count_q != '0);
  assign data_out  = mem_q[0];
  assign count_out = count_q;

endmodule

// File: rtl/fakeram130_256x95_ctrl.sv
// Valid/ready front end for the fakeram130_256x95 1RW macro with credit-protected read returns.
// Optional post-reset zero-fill sweep is enabled by defining FAKERAM_CTRL_ZERO_INIT_EN.
module fakeram130_256x95_ctrl
  import fakeram130_ctrl_pkg::*;
#(
  parameter int unsigned BITS       = DefBits,
  parameter int unsigned WORD_DEPTH = DefWordDepth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RSP_ELS    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n_in,
  input  logic                  req_v_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [BITS-1:0]       req_data_in,
  input  logic [BITS-1:0]       req_mask_in,
  output logic                  rsp_v_out,
  input  logic                  rsp_ready_in,
  output logic [BITS-1:0]       rsp_data_out,
  output logic                  busy_out,
  output logic                  ram_ce_out,
  output logic                  ram_we_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [BITS-1:0]       ram_wd_out,
  output logic [BITS-1:0]       ram_w_mask_out,
  input  logic [BITS-1:0]       ram_rd_in
);

  localparam int unsigned CntW = $clog2(RSP_ELS + 1);

  fakeram_ctrl_state_e   state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  accept, pop;
  logic                  init_active;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [CntW-1:0]       fifo_count, count_next;
  logic [CntW:0]         used_next;

`ifdef FAKERAM_CTRL_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + ADDR_WIDTH'(1);
      if (sweep_q == ADDR_WIDTH'(WORD_DEPTH - 1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign init_active = (state_q == INIT);
  assign sweep_addr  = sweep_q;
`else
  assign state_q     = RUN;
  assign state_d     = RUN;
  assign init_active = 1'b0;
  assign sweep_addr  = '0;
`endif

  assign busy_out = init_active;
  assign accept   = req_v_in & ready_q;
  assign pop      = rsp_v_out & rsp_ready_in;

  // Credits count reads accepted but not yet popped; writes share the gate.
  always_comb begin
    rd_pending_d = accept & ~req_we_in;
    count_next   = fifo_count + CntW'(rd_pending_q) - CntW'(pop);
    used_next    = {1'b0, count_next} + (CntW + 1)'(rd_pending_d);
    ready_d      = (state_d == RUN) && (used_next < (CntW + 1)'(RSP_ELS));
  end

  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ready_q      <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign req_ready_out = ready_q;

  always_comb begin
    ram_ce_out     = accept;
    ram_we_out     = accept & req_we_in;
    ram_addr_out   = req_addr_in;
    ram_wd_out     = req_data_in;
    ram_w_mask_out = req_mask_in;
    if (init_active) begin
      ram_ce_out     = 1'b1;
      ram_we_out     = 1'b1;
      ram_addr_out   = sweep_addr;
      ram_wd_out     = '0;
      ram_w_mask_out = '1;
    end
  end

  fakeram_ctrl_rsp_fifo #(
    .Width (BITS),
    .Depth (RSP_ELS)
  ) u_rsp_fifo (
    .clk          (clk),
    .rst_n        (reset_n_in),
    .push_in      (rd_pending_q),
    .push_data_in (ram_rd_in),
    .pop_in       (pop),
    .valid_out    (rsp_v_out),
    .data_out     (rsp_data_out),
    .count_out    (fifo_count)
  );

endmodule
